// File: rtl/timer_pkg.sv
// Shared types and digit limits for the mm:ss countdown timer controller.
package timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADED = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  // A preset is a legal mm:ss value only if every BCD digit is within its range.
  function automatic logic preset_valid(input logic [15:0] p);
    return (p[15:12] <= TENS_MAX) && (p[11:8] <= UNITS_MAX) &&
           (p[7:4]   <= TENS_MAX) && (p[3:0]  <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts while run is high and flags the last cycle of each second.
module tick_gen #(
  parameter int CLK_PER_SEC = 100
) (
  input  logic clk,
  input  logic clearneg,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == LAST);

  // When run is low the count holds, so a paused second resumes where it left off.
  always_ff @(posedge clk or negedge clearneg) begin
    if (!clearneg) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign tick = run & w_last;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: validates and loads the mm:ss preset, paces the digit
// counters with a one-second enable, and handles pause/resume and completion.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        clearneg,
  input  logic [15:0] preset,
  input  logic        keyload,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  zero_in,
  output logic [15:0] data,
  output logic        loadneg,
  output logic        en,
  output logic        done,
  output logic        err
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_data;
  logic        r_loadneg;
  logic        r_err;

  logic        w_valid;
  logic        w_all_zero;
  logic        w_load;
  logic        w_err;
  logic        w_clr;
  logic        w_run;
  logic        w_tick;

  assign w_valid    = preset_valid(preset);
  assign w_all_zero = (zero_in == 4'hF);

  // Priority everywhere: keyload, then stop, then start. In RUN keyload is ignored.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_err        = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (keyload) begin
          if (w_valid) begin
            w_load       = 1'b1;
            w_state_next = S_LOADED;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_LOADED, S_PAUSE: begin
        if (keyload) begin
          if (w_valid) begin
            w_load       = 1'b1;
            w_state_next = S_LOADED;
          end else begin
            w_err = 1'b1;
          end
        end else if (start && !stop) begin
          w_clr        = (r_state == S_LOADED);
          w_state_next = w_all_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_all_zero) begin
          w_state_next = S_DONE;
        end else if (stop) begin
          w_state_next = S_PAUSE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The prescaler only advances in cycles that stay in RUN, so stop and
  // completion cycles neither tick nor move the count.
  assign w_run = (r_state == S_RUN) && !w_all_zero && !stop;

  tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick (
    .clk      (clk),
    .clearneg (clearneg),
    .run      (w_run),
    .clr      (w_clr),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or negedge clearneg) begin
    if (!clearneg) begin
      r_state   <= S_IDLE;
      r_data    <= 16'h0000;
      r_loadneg <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_loadneg <= ~w_load;
      r_err     <= w_err;
      if (w_load) begin
        r_data <= preset;
      end
    end
  end

  assign data    = r_data;
  assign loadneg = r_loadneg;
  assign err     = r_err;
  assign en      = w_tick;
  assign done    = (r_state == S_DONE);

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter CLK_PER_SEC, default 100, SHALL set the number of clk cycles per one-second count tick (legal range 2..2^24).
REQ-002 Port clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 Port clearneg  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port preset  input  16  SHALL carry the BCD value mm:ss as [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
REQ-005 Port keyload  input  1  SHALL request loading of preset.
REQ-006 Port start  input  1  SHALL request counting to begin or resume.
REQ-007 Port stop  input  1  SHALL request a pause.
REQ-008 Port zero_in  input  4  SHALL carry the per-digit zero flags from the four digit counters, same bit order as preset.
REQ-009 Port data  output  16  SHALL carry the latched BCD load value to the digit counters.
REQ-010 Port loadneg  output  1  SHALL be the active-low synchronous load strobe to the digit counters.
REQ-011 Port en  output  1  SHALL be the one-cycle count-enable tick to the digit counters.
REQ-012 Port done  output  1  SHALL be high while the controller is in DONE.
REQ-013 Port err  output  1  SHALL pulse high for one cycle when a keyload is rejected.

Function
REQ-014 The state machine SHALL have the states IDLE, LOADED, RUN, PAUSE and DONE.
REQ-015 A preset SHALL be valid only if both tens digits are <=5 and both units digits are <=9.
REQ-016 A keyload in IDLE, PAUSE or DONE with a valid preset SHALL latch preset into data, drive loadneg=0 for exactly the next cycle, and enter LOADED.
REQ-017 A keyload with an invalid preset SHALL leave data and state unchanged and pulse err the next cycle.
REQ-018 A keyload in LOADED SHALL reload data and re-strobe loadneg; a keyload in RUN SHALL be ignored without an err pulse.
REQ-019 A start in LOADED or PAUSE SHALL enter RUN when zero_in != 4'b1111, and SHALL enter DONE otherwise.
REQ-020 On entry to RUN from LOADED, the prescaler SHALL clear to 0; on resume from PAUSE, it SHALL keep its held value.
REQ-021 In RUN, the prescaler SHALL count 0..CLK_PER_SEC-1 and wrap, with en=1 for exactly the one cycle in which the prescaler equals CLK_PER_SEC-1.
REQ-022 In RUN, the controller SHALL enter DONE on the first cycle in which zero_in == 4'b1111, and en SHALL be 0 in that cycle.
REQ-023 A stop in RUN SHALL enter PAUSE with en=0 in that cycle; the prescaler SHALL hold.
REQ-024 If start and stop are asserted in the same cycle, stop SHALL win.
REQ-025 If keyload and start are asserted in the same cycle, keyload SHALL win.
REQ-026 In DONE, done SHALL be 1 and start and stop SHALL be ignored.
REQ-027 Outside RUN, en SHALL be 0 at all times.
REQ-028 Outside the single load cycle, loadneg SHALL be 1 at all times.

Reset
REQ-029 While clearneg=0, the outputs SHALL be: state=IDLE, data=16'h0000, loadneg=1, en=0, done=0, err=0, prescaler=0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately with no further en pulse.
REQ-031 After reset release, the first action SHALL take effect on the first rising edge.

Structure
REQ-032 A shared package timer_pkg SHALL hold the state enumeration and the digit limit constants (tens max 5, units max 9).
REQ-033 The prescaler SHALL be a sub-module tick_gen with inputs clk, clearneg, run and clr, and output tick.

Verification (bench CLK_PER_SEC=4)
REQ-034 Scenario: reset, then keyload with preset=16'h0130 -> data=16'h0130 and loadneg=0 for exactly one cycle, state=LOADED.
REQ-035 Scenario: start with zero_in=4'b0000 held -> en pulses on the 4th, 8th and 12th cycles after RUN entry, each one cycle wide.
REQ-036 Scenario: in RUN, stop asserted one cycle after an en pulse, then start 10 cycles later -> no en pulse during PAUSE; the next en pulse arrives 3 cycles after RUN re-entry.
REQ-037 Scenario: in RUN, zero_in driven to 4'b1111 -> DONE and done=1 on the next cycle, no en pulse; a later start is ignored.
REQ-038 Scenario: keyload with preset=16'h0960 (sec tens=6) -> err pulses for one cycle, and data, state and loadneg are unchanged.
REQ-039 Scenario: start and stop asserted together in LOADED -> state stays LOADED; clearneg=0 pulsed mid-RUN -> IDLE with en=0 at once.
